// File: rtl/hora_sync_ctrl.sv
// Frames "T HHMMSS CR" time-set commands from the UART byte stream, range-checks them,
// loads packed BCD into the clock core and requests a resync after RESYNC_S seconds.
module hora_sync_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned RESYNC_S    = 3600
) (
    input  logic        clk,
    input  logic        init,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tick_1hz,
    output logic [23:0] hora_bcd,
    output logic        load,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        resync_req
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned CW = $clog2(RESYNC_S + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(RESYNC_S);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_TERM    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_LOAD    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic time_ok(input logic [23:0] t);
        logic ok;
        ok = (t[23:20] <= 4'd2) && (t[15:12] <= 4'd5) && (t[7:4] <= 4'd5);
        if ((t[23:20] == 4'd2) && (t[19:16] > 4'd3)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    function automatic logic [23:0] put_digit(input logic [23:0] s, input logic [2:0] i,
                                              input logic [3:0] d);
        logic [23:0] r;
        case (i)
            3'd0:    r = {d, s[19:0]};
            3'd1:    r = {s[23:20], d, s[15:0]};
            3'd2:    r = {s[23:16], d, s[11:0]};
            3'd3:    r = {s[23:12], d, s[7:0]};
            3'd4:    r = {s[23:8], d, s[3:0]};
            3'd5:    r = {s[23:4], d};
            default: r = s;
        endcase
        return r;
    endfunction

    state_t          state_r, state_s;
    logic [2:0]      idx_r, idx_s;
    logic [TW-1:0]   timer_r, timer_s;
    logic [23:0]     stage_r, stage_s;
    logic [23:0]     hora_r, hora_s;
    logic            done_r, done_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            load_r, err_r, busy_r, resync_r;
    logic            byte_t_s;

    assign byte_t_s = (rx_data == 8'h54);

    // Next-state logic for the frame sequencer, index, idle timer and staging
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        timer_s = timer_r;
        stage_s = stage_r;
        case (state_r)
            ST_IDLE: begin
                idx_s   = 3'd0;
                timer_s = '0;
                if (rx_valid && byte_t_s) begin
                    state_s = ST_COLLECT;
                    stage_s = 24'h000000;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT, ST_TERM: begin
                if (rx_valid) begin
                    timer_s = '0;
                    if (byte_t_s) begin
                        state_s = ST_COLLECT;
                        idx_s   = 3'd0;
                        stage_s = 24'h000000;
                    end else if ((state_r == ST_COLLECT) && is_digit(rx_data)) begin
                        stage_s = put_digit(stage_r, idx_r, rx_data[3:0]);
                        idx_s   = idx_r + 3'd1;
                        state_s = (idx_r == 3'd5) ? ST_TERM : ST_COLLECT;
                    end else if ((state_r == ST_TERM) && (rx_data == 8'h0D)) begin
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_ERROR;
                    end
                end else if (timer_r == TIMER_MAX) begin
                    state_s = ST_ERROR;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            ST_CHECK: state_s = time_ok(stage_r) ? ST_LOAD : ST_ERROR;
            ST_LOAD:  state_s = ST_IDLE;
            ST_ERROR: begin
                stage_s = 24'h000000;
                state_s = ST_IDLE;
            end
            default:  state_s = ST_IDLE;
        endcase
    end

    // Loaded time, done flag and saturating seconds-since-load counter; load beats a tick
    always_comb begin
        hora_s = hora_r;
        done_s = done_r;
        cnt_s  = cnt_r;
        if ((state_r == ST_CHECK) && (state_s == ST_LOAD)) begin
            hora_s = stage_r;
            done_s = 1'b1;
        end else begin
            hora_s = hora_r;
        end
        if (state_r == ST_LOAD) begin
            cnt_s = '0;
        end else if (tick_1hz && (cnt_r != CNT_MAX)) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State and datapath registers; outputs are registered from next-state values
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state_r  <= ST_IDLE;
            idx_r    <= 3'd0;
            timer_r  <= '0;
            stage_r  <= 24'h000000;
            hora_r   <= 24'h000000;
            done_r   <= 1'b0;
            cnt_r    <= '0;
            load_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            resync_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            timer_r  <= timer_s;
            stage_r  <= stage_s;
            hora_r   <= hora_s;
            done_r   <= done_s;
            cnt_r    <= cnt_s;
            load_r   <= (state_s == ST_LOAD);
            err_r    <= (state_s == ST_ERROR);
            busy_r   <= (state_s != ST_IDLE);
            resync_r <= (cnt_s == CNT_MAX);
        end
    end

    assign hora_bcd   = hora_r;
    assign load       = load_r;
    assign done       = done_r;
    assign err        = err_r;
    assign busy       = busy_r;
    assign resync_req = resync_r;

endmodule

// File: tb/tb_hora_sync_ctrl.sv
// Directed bench for hora_sync_ctrl with short timeout (100 cycles) and resync (3 s) settings.
module tb_hora_sync_ctrl;

    logic        clk = 1'b0;
    logic        init;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tick_1hz;
    logic [23:0] hora_bcd;
    logic        load, done, err, busy, resync_req;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int load_cnt = 0;
    int e0, l0;

    always #5 clk = ~clk;

    hora_sync_ctrl #(.TIMEOUT_CYC(100), .RESYNC_S(3)) dut (
        .clk(clk), .init(init), .rx_data(rx_data), .rx_valid(rx_valid),
        .tick_1hz(tick_1hz), .hora_bcd(hora_bcd), .load(load), .done(done),
        .err(err), .busy(busy), .resync_req(resync_req)
    );

    // Pulse counters sample the pre-edge output values
    always @(posedge clk) begin
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (load === 1'b1) load_cnt <= load_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            step(gap);
        end
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input logic [23:0] exp_hora);
        send_byte(8'h0D);
        chk({tag, "_check_load"}, {31'd0, load}, 32'd0);
        chk({tag, "_check_busy"}, {31'd0, busy}, 32'd1);
        step(1);
        chk({tag, "_load"}, {31'd0, load}, 32'd1);
        chk({tag, "_hora"}, {8'd0, hora_bcd}, {8'd0, exp_hora});
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        step(1);
        chk({tag, "_load_end"}, {31'd0, load}, 32'd0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        init = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tick_1hz = 1'b0;
        step(3);
        chk("reset_outputs", {3'd0, hora_bcd, load, done, err, busy, resync_req}, 32'd0);
        init = 1'b1;
        step(1);

        // Full valid frame with gaps
        e0 = err_cnt; l0 = load_cnt;
        send_byte(8'h54);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        step(2);
        send_str("235959", 3);
        finish_frame("f235959", 24'h235959);
        step(1);
        chk("f235959_loads", load_cnt - l0, 32'd1);
        chk("f235959_no_err", err_cnt - e0, 32'd0);

        // Range failures: hour 24, minute 60
        e0 = err_cnt; l0 = load_cnt;
        send_str("T245959", 1);
        send_byte(8'h0D);
        chk("range_h_check", {31'd0, err}, 32'd0);
        step(1);
        chk("range_h_err", {31'd0, err}, 32'd1);
        step(1);
        chk("range_h_err_end", {30'd0, err, busy}, 32'd0);
        send_str("T126000\r", 1);
        step(2);
        chk("range_err_count", err_cnt - e0, 32'd2);
        chk("range_no_load", load_cnt - l0, 32'd0);
        chk("range_hora_kept", {8'd0, hora_bcd}, 32'h00235959);

        // Bad character, then immediate new frame at midnight
        send_str("T12", 1);
        send_byte(8'h61);
        chk("badchar_err", {31'd0, err}, 32'd1);
        step(1);
        chk("badchar_idle", {30'd0, err, busy}, 32'd0);
        send_byte(8'h54);
        chk("badchar_retry_busy", {31'd0, busy}, 32'd1);
        send_str("000000", 0);
        finish_frame("midnight", 24'h000000);

        // Restart on T mid-frame, then junk in IDLE
        e0 = err_cnt;
        send_str("T12T083015", 1);
        finish_frame("restart", 24'h083015);
        step(1);
        chk("restart_no_err", err_cnt - e0, 32'd0);
        send_byte(8'h78);
        chk("junk_x_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h79);
        chk("junk_y_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h7A);
        chk("junk_z_busy", {31'd0, busy}, 32'd0);

        // Timeout 100 cycles after the last accepted byte
        e0 = err_cnt;
        send_str("T12", 0);
        step(99);
        chk("timeout_early_err", {31'd0, err}, 32'd0);
        chk("timeout_early_busy", {31'd0, busy}, 32'd1);
        chk("timeout_early_cnt", err_cnt - e0, 32'd0);
        step(1);
        chk("timeout_err", {31'd0, err}, 32'd1);
        step(1);
        chk("timeout_busy_drop", {31'd0, busy}, 32'd0);
        send_str("T101010", 2);
        finish_frame("after_timeout", 24'h101010);

        // Resync request after 3 ticks; load with coincident tick clears it
        pulse_tick();
        pulse_tick();
        chk("resync_two_ticks", {31'd0, resync_req}, 32'd0);
        pulse_tick();
        chk("resync_set", {31'd0, resync_req}, 32'd1);
        send_str("T111111", 1);
        send_byte(8'h0D);
        chk("resync_hold_check", {31'd0, resync_req}, 32'd1);
        step(1);
        chk("resync_load", {31'd0, load}, 32'd1);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        chk("resync_clear", {31'd0, resync_req}, 32'd0);
        pulse_tick();
        pulse_tick();
        chk("resync_cnt_zero", {31'd0, resync_req}, 32'd0);
        pulse_tick();
        chk("resync_reset_set", {31'd0, resync_req}, 32'd1);

        // Asynchronous reset in the middle of a frame
        send_str("T1234", 1);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        #2 init = 1'b0;
        #1 chk("async_reset", {3'd0, hora_bcd, load, done, err, busy, resync_req}, 32'd0);
        @(negedge clk);
        init = 1'b1;
        step(1);
        chk("post_reset", {3'd0, hora_bcd, load, done, err, busy, resync_req}, 32'd0);
        send_str("T203040", 1);
        finish_frame("post_reset_frame", 24'h203040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
